// File: rtl/lfsr_pkg.sv
// Shared definitions for the parametrised LFSR generator: maximal-length tap
// masks, the default prescaler ratio and the one-step feedback function.
package lfsr_pkg;

  // One second of ticks from a 100 MHz board clock.
  localparam int unsigned DIV_100MHZ_1S = 100_000_000;

  // Maximal-length feedback masks, bit i set => state[i] feeds the XOR.
  function automatic logic [31:0] default_taps(input int unsigned width);
    logic [31:0] taps;
    case (width)
      3:       taps = 32'h0000_0006;
      4:       taps = 32'h0000_000C;
      5:       taps = 32'h0000_0014;
      6:       taps = 32'h0000_0030;
      7:       taps = 32'h0000_0060;
      8:       taps = 32'h0000_00B8;
      9:       taps = 32'h0000_0110;
      10:      taps = 32'h0000_0240;
      11:      taps = 32'h0000_0500;
      12:      taps = 32'h0000_0829;
      13:      taps = 32'h0000_100D;
      14:      taps = 32'h0000_2015;
      15:      taps = 32'h0000_6000;
      16:      taps = 32'h0000_D008;
      17:      taps = 32'h0001_2000;
      18:      taps = 32'h0002_0400;
      19:      taps = 32'h0004_0023;
      20:      taps = 32'h0009_0000;
      21:      taps = 32'h0014_0000;
      22:      taps = 32'h0030_0000;
      23:      taps = 32'h0042_0000;
      24:      taps = 32'h00E1_0000;
      25:      taps = 32'h0120_0000;
      26:      taps = 32'h0200_0023;
      27:      taps = 32'h0400_0013;
      28:      taps = 32'h0900_0000;
      29:      taps = 32'h1400_0000;
      30:      taps = 32'h2000_0029;
      31:      taps = 32'h4800_0000;
      32:      taps = 32'h8020_0003;
      default: taps = 32'h0000_00B8;
    endcase
    return taps;
  endfunction

  // Fibonacci step: shift left, feedback parity enters at bit 0, result
  // trimmed to the register width.
  function automatic logic [31:0] lfsr_next(input logic [31:0] state,
                                            input logic [31:0] taps,
                                            input int unsigned width);
    logic [32:0] mask;
    logic        fb;
    mask = (33'd1 << width) - 33'd1;
    fb   = ^(state & taps);
    return {state[30:0], fb} & mask[31:0];
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Run-time programmable divider producing a one-cycle tick every div clocks
// while enabled.
module tick_prescaler
  import lfsr_pkg::*;
#(
  parameter int unsigned          DIV_WIDTH = 27,
  parameter logic [DIV_WIDTH-1:0] DIV_RESET = DIV_WIDTH'(DIV_100MHZ_1S)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 div_load,
  input  logic [DIV_WIDTH-1:0] div_value,
  input  logic                 clear,
  output logic                 tick
);

  localparam logic [DIV_WIDTH-1:0] ONE = DIV_WIDTH'(1);

  logic [DIV_WIDTH-1:0] div_q;
  logic [DIV_WIDTH-1:0] cnt_q;
  logic                 at_end;

  // Terminal count detection; a reload or clear in the same cycle suppresses the tick.
  always_comb begin
    at_end = (cnt_q == div_q - ONE);
    tick   = enable & at_end & ~div_load & ~clear;
  end

  // Divide ratio and counter; a zero ratio is stored as one (tick every cycle).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q <= DIV_RESET;
      cnt_q <= '0;
    end else begin
      // NOTE: registers take <= so every flop samples pre-edge values; = here would chain them.
      if (div_load)
        div_q <= (div_value == '0) ? ONE : div_value;
      if (div_load || clear)
        cnt_q <= '0;
      else if (enable)
        cnt_q <= at_end ? '0 : cnt_q + ONE;
    end
  end

endmodule

// File: rtl/lfsr_rng_param.sv
// Parametrised Fibonacci LFSR random word source with prescaled ticks,
// single-step, seed reload, valid/ready output, overrun and wrap flags.
module lfsr_rng_param
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] TAPS        = WIDTH'(default_taps(WIDTH)),
  parameter logic [WIDTH-1:0] SEED        = WIDTH'(13),
  parameter int unsigned      DIV_WIDTH   = 27,
  parameter int unsigned      DIV_DEFAULT = DIV_100MHZ_1S
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 div_load,
  input  logic [DIV_WIDTH-1:0] div_value,
  input  logic                 seed_load,
  input  logic [WIDTH-1:0]     seed_value,
  input  logic                 step,
  output logic [WIDTH-1:0]     rnd,
  output logic                 rnd_valid,
  input  logic                 rnd_ready,
  output logic                 overrun,
  input  logic                 clr_overrun,
  output logic                 wrap
);

  localparam logic [DIV_WIDTH-1:0] DIV_RESET =
    DIV_WIDTH'((DIV_DEFAULT == 0) ? 1 : DIV_DEFAULT);

  logic             tick;
  logic             adv;
  logic             overrun_set;
  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] seed_ref_q;
  logic [WIDTH-1:0] next_raw;
  logic [WIDTH-1:0] next_word;
  logic [WIDTH-1:0] load_word;
  logic             valid_q;
  logic             overrun_q;
  logic             wrap_q;

  tick_prescaler #(
    .DIV_WIDTH (DIV_WIDTH),
    .DIV_RESET (DIV_RESET)
  ) u_prescaler (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .div_load  (div_load),
    .div_value (div_value),
    .clear     (seed_load),
    .tick      (tick)
  );

  // Next word with lock-up guard, seed substitution and advance request.
  always_comb begin
    // NOTE: each always_comb output is assigned on every path, so no latch can be inferred.
    next_raw    = WIDTH'(lfsr_next(32'(state_q), 32'(TAPS), WIDTH));
    next_word   = (next_raw == '0) ? SEED : next_raw;
    load_word   = (seed_value == '0) ? SEED : seed_value;
    adv         = tick | step;
    overrun_set = adv & ~seed_load & valid_q & ~rnd_ready;
  end

  // LFSR state, seed reference, output valid and wrap pulse; seed load beats advance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= SEED;
      seed_ref_q <= SEED;
      valid_q    <= 1'b0;
      wrap_q     <= 1'b0;
    end else if (seed_load) begin
      state_q    <= load_word;
      seed_ref_q <= load_word;
      valid_q    <= 1'b0;
      wrap_q     <= 1'b0;
    end else if (adv) begin
      state_q    <= next_word;
      valid_q    <= 1'b1;
      wrap_q     <= (next_word == seed_ref_q);
    end else begin
      wrap_q     <= 1'b0;
      if (valid_q && rnd_ready)
        valid_q  <= 1'b0;
    end
  end

  // Sticky overrun: set has priority over clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      overrun_q <= 1'b0;
    else
      overrun_q <= overrun_set | (overrun_q & ~clr_overrun);
  end

  assign rnd       = state_q;
  assign rnd_valid = valid_q;
  assign overrun   = overrun_q;
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_lfsr_rng_param.sv
// Bench for lfsr_rng_param (WIDTH=8, taps 8'hB8, seed 13, divide ratio 4).
module tb_lfsr_rng_param;

  localparam int W  = 8;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable, div_load, seed_load, step, rnd_ready, clr_overrun;
  logic [DW-1:0] div_value;
  logic [W-1:0]  seed_value;
  logic [W-1:0]  rnd;
  logic          rnd_valid, overrun, wrap;

  int n_cmp = 0;
  int n_bad = 0;

  lfsr_rng_param #(
    .WIDTH       (W),
    .DIV_WIDTH   (DW),
    .DIV_DEFAULT (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .div_load    (div_load),
    .div_value   (div_value),
    .seed_load   (seed_load),
    .seed_value  (seed_value),
    .step        (step),
    .rnd         (rnd),
    .rnd_valid   (rnd_valid),
    .rnd_ready   (rnd_ready),
    .overrun     (overrun),
    .clr_overrun (clr_overrun),
    .wrap        (wrap)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference step: multiply by two modulo 256, add parity of the tapped bits.
  function automatic int ref_next(input int s);
    int taps = 'hB8;
    int p = 0;
    int n;
    for (int i = 0; i < 8; i++)
      if (((s >> i) & 1) == 1 && ((taps >> i) & 1) == 1) p = 1 - p;
    n = (s * 2 + p) % 256;
    return (n == 0) ? 13 : n;
  endfunction

  // Behavioural model state for the randomized phase.
  int m_state, m_ref, m_cnt, m_div;
  bit m_valid, m_over, m_wrap;

  task automatic model_reset();
    m_state = 13; m_ref = 13; m_cnt = 0; m_div = 4;
    m_valid = 0;  m_over = 0; m_wrap = 0;
  endtask

  task automatic model_cycle();
    bit tk, ad, set_ov;
    int sv;
    tk     = enable && !div_load && !seed_load && (m_cnt == m_div - 1);
    ad     = tk || step;
    set_ov = !seed_load && ad && m_valid && !rnd_ready;
    if (seed_load) begin
      sv = (seed_value == 0) ? 13 : int'(seed_value);
      m_state = sv; m_ref = sv; m_valid = 0; m_wrap = 0;
    end else if (ad) begin
      m_state = ref_next(m_state);
      m_valid = 1;
      m_wrap  = (m_state == m_ref);
    end else begin
      m_wrap = 0;
      if (m_valid && rnd_ready) m_valid = 0;
    end
    m_over = set_ov || (m_over && !clr_overrun);
    if (seed_load || div_load) m_cnt = 0;
    else if (enable) m_cnt = (m_cnt == m_div - 1) ? 0 : m_cnt + 1;
    if (div_load) m_div = (div_value == 0) ? 1 : int'(div_value);
  endtask

  task automatic clear_inputs();
    enable = 0; div_load = 0; div_value = '0; seed_load = 0; seed_value = '0;
    step = 0; rnd_ready = 0; clr_overrun = 0;
  endtask

  task automatic clk_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 0;
    clk_step();
    @(negedge clk);
    reset = 1;
  endtask

  typedef struct {
    string      name;
    bit         en, stp, rdy, clr, sl;
    logic [7:0] sv;
    int         e_rnd;
    bit         e_val, e_ovr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string nm, input bit en, input bit stp, input bit rdy,
                              input bit clr, input bit sl, input logic [7:0] sv,
                              input int er, input bit ev, input bit eo);
    vec_t v;
    v.name = nm; v.en = en; v.stp = stp; v.rdy = rdy; v.clr = clr; v.sl = sl; v.sv = sv;
    v.e_rnd = er; v.e_val = ev; v.e_ovr = eo;
    return v;
  endfunction

  initial begin
    int prev, adv_cnt, wraps, wrap_at, wrap_val, zero_seen, chain_err, m;

    // T1: prescaled sequence, one advance every 4 clocks, valid pulses of one clock.
    vecs.push_back(mk("t1_0",  1,0,1,0,0,8'h00,  13,0,0));
    vecs.push_back(mk("t1_1",  1,0,1,0,0,8'h00,  13,0,0));
    vecs.push_back(mk("t1_2",  1,0,1,0,0,8'h00,  13,0,0));
    vecs.push_back(mk("t1_3",  1,0,1,0,0,8'h00,  27,1,0));
    vecs.push_back(mk("t1_4",  1,0,1,0,0,8'h00,  27,0,0));
    vecs.push_back(mk("t1_5",  1,0,1,0,0,8'h00,  27,0,0));
    vecs.push_back(mk("t1_6",  1,0,1,0,0,8'h00,  27,0,0));
    vecs.push_back(mk("t1_7",  1,0,1,0,0,8'h00,  54,1,0));
    vecs.push_back(mk("t1_8",  1,0,1,0,0,8'h00,  54,0,0));
    vecs.push_back(mk("t1_9",  1,0,1,0,0,8'h00,  54,0,0));
    vecs.push_back(mk("t1_10", 1,0,1,0,0,8'h00,  54,0,0));
    vecs.push_back(mk("t1_11", 1,0,1,0,0,8'h00, 108,1,0));
    // T3: single steps with the prescaler frozen, then step coincident with tick.
    vecs.push_back(mk("t3_0",  0,1,1,0,0,8'h00, 216,1,0));
    vecs.push_back(mk("t3_1",  0,0,1,0,0,8'h00, 216,0,0));
    vecs.push_back(mk("t3_2",  0,1,1,0,0,8'h00, 177,1,0));
    vecs.push_back(mk("t3_3",  0,1,1,0,0,8'h00,  99,1,0));
    vecs.push_back(mk("t3_4",  1,0,1,0,0,8'h00,  99,0,0));
    vecs.push_back(mk("t3_5",  1,0,1,0,0,8'h00,  99,0,0));
    vecs.push_back(mk("t3_6",  1,0,1,0,0,8'h00,  99,0,0));
    vecs.push_back(mk("t3_7",  1,1,1,0,0,8'h00, 199,1,0));
    // T4: overrun set, clear, and set+clear in the same cycle.
    vecs.push_back(mk("t4_0",  1,0,1,0,0,8'h00, 199,0,0));
    vecs.push_back(mk("t4_1",  1,0,0,0,0,8'h00, 199,0,0));
    vecs.push_back(mk("t4_2",  1,0,0,0,0,8'h00, 199,0,0));
    vecs.push_back(mk("t4_3",  1,0,0,0,0,8'h00, 143,1,0));
    vecs.push_back(mk("t4_4",  1,0,0,0,0,8'h00, 143,1,0));
    vecs.push_back(mk("t4_5",  1,0,0,0,0,8'h00, 143,1,0));
    vecs.push_back(mk("t4_6",  1,0,0,0,0,8'h00, 143,1,0));
    vecs.push_back(mk("t4_7",  1,0,0,0,0,8'h00,  30,1,1));
    vecs.push_back(mk("t4_8",  0,0,0,1,0,8'h00,  30,1,0));
    vecs.push_back(mk("t4_9",  0,1,0,1,0,8'h00,  60,1,1));
    vecs.push_back(mk("t4_10", 0,0,0,0,0,8'h00,  60,1,1));
    vecs.push_back(mk("t4_11", 0,0,1,1,0,8'h00,  60,0,0));
    // T5: zero seed falls back to 13; seed load on a tick drops the advance.
    vecs.push_back(mk("t5_0",  0,1,0,0,0,8'h00, 121,1,0));
    vecs.push_back(mk("t5_1",  0,0,0,0,1,8'h00,  13,0,0));
    vecs.push_back(mk("t5_2",  1,0,0,0,0,8'h00,  13,0,0));
    vecs.push_back(mk("t5_3",  1,0,0,0,0,8'h00,  13,0,0));
    vecs.push_back(mk("t5_4",  1,0,0,0,0,8'h00,  13,0,0));
    vecs.push_back(mk("t5_5",  1,0,0,0,1,8'hA5, 165,0,0));
    vecs.push_back(mk("t5_6",  1,0,0,0,0,8'h00, 165,0,0));
    vecs.push_back(mk("t5_7",  1,0,0,0,0,8'h00, 165,0,0));
    vecs.push_back(mk("t5_8",  1,0,0,0,0,8'h00, 165,0,0));
    vecs.push_back(mk("t5_9",  1,0,0,0,0,8'h00,  74,1,0));

    // Reset state.
    clear_inputs();
    reset = 0;
    clk_step();
    clk_step();
    check("reset_rnd",     rnd,       13);
    check("reset_valid",   rnd_valid, 0);
    check("reset_overrun", overrun,   0);
    check("reset_wrap",    wrap,      0);
    @(negedge clk);
    reset = 1;

    foreach (vecs[i]) begin
      enable = vecs[i].en; step = vecs[i].stp; rnd_ready = vecs[i].rdy;
      clr_overrun = vecs[i].clr; seed_load = vecs[i].sl; seed_value = vecs[i].sv;
      div_load = 0; div_value = '0;
      clk_step();
      check({vecs[i].name, "_rnd"},   rnd,       vecs[i].e_rnd);
      check({vecs[i].name, "_valid"}, rnd_valid, vecs[i].e_val);
      check({vecs[i].name, "_ovr"},   overrun,   vecs[i].e_ovr);
      check({vecs[i].name, "_wrap"},  wrap,      0);
    end

    // T6: divide ratio 0 acts as 1, then asynchronous reset mid-operation.
    clear_inputs();
    enable = 1; rnd_ready = 1; div_load = 1; div_value = '0;
    clk_step();
    check("t6_load_rnd",   rnd,       74);
    check("t6_load_valid", rnd_valid, 0);
    div_load = 0;
    m = 74;
    for (int k = 0; k < 4; k++) begin
      clk_step();
      m = ref_next(m);
      check($sformatf("t6_div1_%0d_rnd", k),   rnd,       m);
      check($sformatf("t6_div1_%0d_valid", k), rnd_valid, 1);
    end
    rnd_ready = 0;
    clk_step();
    m = ref_next(m);
    check("t6_ovr_rnd", rnd,     m);
    check("t6_ovr_set", overrun, 1);
    #2 reset = 0;
    #1;
    check("t6_async_rnd",     rnd,       13);
    check("t6_async_valid",   rnd_valid, 0);
    check("t6_async_overrun", overrun,   0);
    check("t6_async_wrap",    wrap,      0);
    clear_inputs();
    @(negedge clk);
    reset = 1;
    enable = 1; rnd_ready = 1;
    for (int k = 1; k <= 4; k++) begin
      clk_step();
      check($sformatf("t6_post_%0d_rnd", k),   rnd,       (k == 4) ? 27 : 13);
      check($sformatf("t6_post_%0d_valid", k), rnd_valid, (k == 4) ? 1 : 0);
    end

    // T2: full period, exactly one wrap on advance 255 back at 13.
    do_reset();
    enable = 1; rnd_ready = 1;
    prev = 13; adv_cnt = 0; wraps = 0; wrap_at = -1; wrap_val = -1; zero_seen = 0; chain_err = 0;
    for (int c = 0; c < 1030; c++) begin
      clk_step();
      if (int'(rnd) != prev) begin
        adv_cnt++;
        if (int'(rnd) != ref_next(prev)) chain_err++;
        prev = int'(rnd);
      end
      if (rnd == 0) zero_seen++;
      if (wrap === 1'b1) begin
        wraps++;
        wrap_at = adv_cnt;
        wrap_val = int'(rnd);
      end
    end
    check("t2_wrap_count", wraps,     1);
    check("t2_wrap_at",    wrap_at,   255);
    check("t2_wrap_rnd",   wrap_val,  13);
    check("t2_chain",      chain_err, 0);
    check("t2_zero",       zero_seen, 0);
    check("t2_advances",   adv_cnt,   257);

    // Randomized run against the behavioural model.
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      enable      = ($urandom_range(0, 3) != 0);
      step        = ($urandom_range(0, 7) == 0);
      rnd_ready   = $urandom_range(0, 1) == 1;
      clr_overrun = ($urandom_range(0, 7) == 0);
      div_load    = ($urandom_range(0, 31) == 0);
      div_value   = 8'($urandom_range(0, 3));
      seed_load   = ($urandom_range(0, 63) == 0);
      seed_value  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      model_cycle();
      clk_step();
      check($sformatf("rand_%0d_rnd", c),   rnd,       m_state);
      check($sformatf("rand_%0d_valid", c), rnd_valid, m_valid);
      check($sformatf("rand_%0d_ovr", c),   overrun,   m_over);
      check($sformatf("rand_%0d_wrap", c),  wrap,      m_wrap);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
